// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, idle column
// pattern, single-low column decoder and the key codes used by the game logic.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DEBOUNCE_P = 2'd1,
    PRESSED    = 2'd2,
    DEBOUNCE_R = 2'd3
  } kp_state_e;

  localparam logic [3:0] COL_IDLE = 4'hf;

  localparam logic [3:0] KEY_UP    = 4'h1;
  localparam logic [3:0] KEY_LEFT  = 4'h4;
  localparam logic [3:0] KEY_RIGHT = 4'h6;
  localparam logic [3:0] KEY_DOWN  = 4'h9;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } col_hit_t;

  // Exactly one low column is a key; idle or several lows (ghosting) is "no key".
  function automatic col_hit_t onehot_low_to_idx(input logic [3:0] col_bits);
    col_hit_t hit;
    hit = '0;
    case (col_bits)
      4'b1110: begin hit.valid = 1'b1; hit.idx = 2'd0; end
      4'b1101: begin hit.valid = 1'b1; hit.idx = 2'd1; end
      4'b1011: begin hit.valid = 1'b1; hit.idx = 2'd2; end
      4'b0111: begin hit.valid = 1'b1; hit.idx = 2'd3; end
      default: hit = '0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/keypad_slot_timer.sv
// Row slot timer: counts SCAN_DIV cycles per row, strobes the settle/sample point
// (which is also the slot wrap) and rotates row_idx unless frozen.
module keypad_slot_timer #(
  parameter int SCAN_DIV = 1024
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       freeze,
  output logic       sample_stb,
  output logic [1:0] row_idx
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] slot_cnt_reg;
  logic [1:0]       row_idx_reg;

  assign sample_stb = (slot_cnt_reg == CNT_LAST);
  assign row_idx    = row_idx_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_cnt_reg <= '0;
      row_idx_reg  <= 2'd0;
    end else begin
      slot_cnt_reg <= sample_stb ? '0 : slot_cnt_reg + CNT_W'(1);
      if (sample_stb && !freeze) begin
        row_idx_reg <= row_idx_reg + 2'd1;
      end
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: strobes rows low, debounces the column reading and emits
// {row,col} key codes. Optional auto-repeat in PRESSED under `KEYPAD_REPEAT_EN.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1024,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_SLOTS = 256
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DC_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT + 1) : 1;
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_CNT);
  localparam bit SINGLE_SAMPLE = (DEBOUNCE_CNT == 1);

  logic [3:0]      col_meta_reg, col_sync_reg;
  logic [3:0]      row_reg, row_next;
  kp_state_e       state_reg, state_next;
  logic [DC_W-1:0] dcnt_reg, dcnt_next, dcnt_inc;
  logic [1:0]      cap_row_reg, cap_row_next;
  logic [1:0]      cap_col_reg, cap_col_next;
  logic [3:0]      key_code_reg, key_code_next;
  logic            key_valid_reg, key_valid_next;
  logic            key_held_reg, key_held_next;
  logic            accept, rel_done, repeat_pulse;
  logic            sample_stb, freeze;
  logic [1:0]      row_idx;
  col_hit_t        samp;

  assign samp   = onehot_low_to_idx(col_sync_reg);
  assign freeze = (state_next != SCAN);

  keypad_slot_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_slot_timer (
    .CLK        (CLK),
    .RST        (RST),
    .freeze     (freeze),
    .sample_stb (sample_stb),
    .row_idx    (row_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      assign row_next[gi] = (row_idx != 2'(gi));
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      col_meta_reg  <= COL_IDLE;
      col_sync_reg  <= COL_IDLE;
      row_reg       <= 4'hf;
      state_reg     <= SCAN;
      dcnt_reg      <= '0;
      cap_row_reg   <= 2'd0;
      cap_col_reg   <= 2'd0;
      key_code_reg  <= 4'h0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      col_meta_reg  <= col;
      col_sync_reg  <= col_meta_reg;
      row_reg       <= row_next;
      state_reg     <= state_next;
      dcnt_reg      <= dcnt_next;
      cap_row_reg   <= cap_row_next;
      cap_col_reg   <= cap_col_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      key_held_reg  <= key_held_next;
    end
  end

  // Decisions are taken only at the settle point; the row is frozen to the captured one
  // whenever the next state is not SCAN, so only column equality needs checking.
  always_comb begin
    state_next   = state_reg;
    dcnt_next    = dcnt_reg;
    cap_row_next = cap_row_reg;
    cap_col_next = cap_col_reg;
    accept       = 1'b0;
    rel_done     = 1'b0;
    dcnt_inc     = dcnt_reg + DC_W'(1);
    if (sample_stb) begin
      unique case (state_reg)
        SCAN: begin
          if (samp.valid) begin
            cap_row_next = row_idx;
            cap_col_next = samp.idx;
            if (SINGLE_SAMPLE) begin
              state_next = PRESSED;
              dcnt_next  = '0;
              accept     = 1'b1;
            end else begin
              state_next = DEBOUNCE_P;
              dcnt_next  = DC_W'(1);
            end
          end
        end
        DEBOUNCE_P: begin
          if (samp.valid && samp.idx == cap_col_reg) begin
            dcnt_next = dcnt_inc;
            if (dcnt_inc == DC_LAST) begin
              state_next = PRESSED;
              dcnt_next  = '0;
              accept     = 1'b1;
            end
          end else begin
            state_next = SCAN;
            dcnt_next  = '0;
          end
        end
        PRESSED: begin
          if (!samp.valid) begin
            if (SINGLE_SAMPLE) begin
              state_next = SCAN;
              dcnt_next  = '0;
              rel_done   = 1'b1;
            end else begin
              state_next = DEBOUNCE_R;
              dcnt_next  = DC_W'(1);
            end
          end
        end
        DEBOUNCE_R: begin
          if (!samp.valid) begin
            dcnt_next = dcnt_inc;
            if (dcnt_inc == DC_LAST) begin
              state_next = SCAN;
              dcnt_next  = '0;
              rel_done   = 1'b1;
            end
          end else if (samp.idx == cap_col_reg) begin
            state_next = PRESSED;
            dcnt_next  = '0;
          end
        end
        default: begin
          state_next = SCAN;
          dcnt_next  = '0;
        end
      endcase
    end
  end

  always_comb begin
    key_valid_next = accept | repeat_pulse;
    key_code_next  = accept ? {cap_row_next, cap_col_next} : key_code_reg;
    key_held_next  = key_held_reg;
    if (accept) begin
      key_held_next = 1'b1;
    end else if (rel_done) begin
      key_held_next = 1'b0;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RP_W = $clog2(REPEAT_SLOTS + 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_SLOTS - 1);

  logic [RP_W-1:0] rep_cnt_reg, rep_cnt_next;

  // Counts slots spent holding in PRESSED; DEBOUNCE_R leaves it untouched.
  always_comb begin
    rep_cnt_next = rep_cnt_reg;
    repeat_pulse = 1'b0;
    if (accept) begin
      rep_cnt_next = '0;
    end else if (sample_stb && state_reg == PRESSED && state_next == PRESSED) begin
      if (rep_cnt_reg == RP_LAST) begin
        rep_cnt_next = '0;
        repeat_pulse = 1'b1;
      end else begin
        rep_cnt_next = rep_cnt_reg + RP_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rep_cnt_reg <= '0;
    end else begin
      rep_cnt_reg <= rep_cnt_next;
    end
  end
`else
  logic repeat_param_unused;
  assign repeat_param_unused = ^REPEAT_SLOTS;
  assign repeat_pulse        = 1'b0;
`endif

  assign row       = row_reg;
  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3) driven by
// a behavioural 4x4 switch matrix; pressed[r*4+c] closes the key at row r, column c.
module tb_keypad_matrix_scanner;

  logic        CLK;
  logic        RST;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] pressed;
  logic [3:0]  scan_seq [0:3];
  int          checks;
  int          errors;
  int          valid_cnt;
  int          dbl_cnt;
  logic        prev_valid;
  logic [3:0]  last_code;
  int          run_len;

  keypad_matrix_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3),
    .REPEAT_SLOTS (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Switch matrix with pull-ups: a column is low if a closed key sits on a driven-low row.
  always_comb begin
    col = 4'hf;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row[r] && pressed[r*4+c]) col[c] = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST && key_valid) begin
      if (prev_valid) dbl_cnt++;
      valid_cnt++;
      last_code = key_code;
    end
    prev_valid = key_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    valid_cnt  = 0;
    dbl_cnt    = 0;
    prev_valid = 1'b0;
    last_code  = 4'h0;
    pressed    = 16'h0;
    scan_seq[0] = 4'he;
    scan_seq[1] = 4'hd;
    scan_seq[2] = 4'hb;
    scan_seq[3] = 4'h7;
    RST = 1'b1;
    repeat (3) @(negedge CLK);

    check_eq("reset_row", row, 4'hf);
    check_eq("reset_code", key_code, 4'h0);
    check_eq("reset_valid", key_valid, 1'b0);
    check_eq("reset_held", key_held, 1'b0);

    // Idle scan: first low row one cycle after release, 4-cycle slots.
    RST = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if ((k - 1) % 4 == 0) check_eq($sformatf("idle_row_k%0d", k), row, scan_seq[((k - 1) / 4) % 4]);
    end
    check_eq("idle_no_valid", valid_cnt, 0);
    check_eq("idle_held", key_held, 1'b0);

    // Stable press of row 2 / col 1 (KEY_DOWN).
    pressed[9] = 1'b1;
    for (int i = 0; i < 40 && key_valid !== 1'b1; i++) @(negedge CLK);
    check_eq("press_valid_seen", key_valid, 1'b1);
    repeat (12) @(negedge CLK);
    check_eq("press_valid_once", valid_cnt, 1);
    check_eq("press_code", last_code, 4'h9);
    check_eq("press_held", key_held, 1'b1);
    check_eq("press_row_frozen", row, 4'hb);

    // Release: three idle samples drop key_held, code is kept, scan moves to row 3.
    pressed[9] = 1'b0;
    for (int i = 0; i < 40 && key_held !== 1'b0; i++) @(negedge CLK);
    check_eq("release_held", key_held, 1'b0);
    check_eq("release_code", key_code, 4'h9);
    @(negedge CLK);
    check_eq("release_resume_row", row, 4'h7);

    // Bounce: one matching sample only; row 2 held for exactly two slots then row 3.
    for (int i = 0; i < 40 && row !== 4'hb; i++) @(negedge CLK);
    run_len = 1;
    pressed[9] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (row === 4'hb) run_len++;
    end
    pressed[9] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (row !== 4'hb) break;
      run_len++;
    end
    check_eq("bounce_row2_cycles", run_len, 8);
    check_eq("bounce_next_row", row, 4'h7);
    check_eq("bounce_no_valid", valid_cnt, 1);

    // Ghosting: keys (0,0) and (0,2) give col=1010 on row 0, which is not a key.
    pressed[0] = 1'b1;
    pressed[2] = 1'b1;
    for (int i = 0; i < 40 && row !== 4'he; i++) @(negedge CLK);
    run_len = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (row !== 4'he) break;
      run_len++;
    end
    check_eq("ghost_row0_cycles", run_len, 4);
    repeat (16) @(negedge CLK);
    check_eq("ghost_no_valid", valid_cnt, 1);
    check_eq("ghost_held", key_held, 1'b0);
    pressed = 16'h0;

    // Reset while a key (row 1 / col 2, KEY_RIGHT) is held.
    pressed[6] = 1'b1;
    for (int i = 0; i < 60 && key_valid !== 1'b1; i++) @(negedge CLK);
    check_eq("right_valid_seen", key_valid, 1'b1);
    check_eq("right_code", key_code, 4'h6);
    repeat (8) @(negedge CLK);
    check_eq("right_held", key_held, 1'b1);
    RST = 1'b1;
    pressed = 16'h0;
    @(negedge CLK);
    check_eq("rst_press_row", row, 4'hf);
    check_eq("rst_press_held", key_held, 1'b0);
    check_eq("rst_press_code", key_code, 4'h0);
    check_eq("rst_press_valid", key_valid, 1'b0);
    RST = 1'b0;
    repeat (24) @(negedge CLK);
    check_eq("rst_no_exit_pulse", valid_cnt, 2);
    check_eq("valid_never_back_to_back", dbl_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
